// File: rtl/regfile_uart_pkg.sv
// Shared definitions for the ASCII register-file UART protocol: frame byte
// constants, hex/ASCII conversion helpers and the response error code.
package regfile_uart_pkg;

    localparam logic [7:0] SOP  = 8'h3C;  // '<'
    localparam logic [7:0] EQ   = 8'h3D;  // '='
    localparam logic [7:0] REQ  = 8'h3F;  // '?'
    localparam logic [7:0] EOP1 = 8'h2F;  // '/'
    localparam logic [7:0] EOP2 = 8'h3E;  // '>'

    typedef enum logic [1:0] {
        ERR_OK        = 2'd0,
        ERR_TIMEOUT   = 2'd1,
        ERR_MALFORMED = 2'd2,
        ERR_ADDR      = 2'd3
    } rsp_err_t;

    function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    // Bit 4 flags a valid digit; lower-case hex is not part of the protocol.
    function automatic logic [4:0] ascii2hex(input logic [7:0] ch);
        logic [4:0] r;
        r = 5'h00;
        if (ch >= 8'h30 && ch <= 8'h39)
            r = {1'b1, ch[3:0]};
        else if (ch >= 8'h41 && ch <= 8'h46)
            r = {1'b1, ch[3:0] + 4'd9};
        return r;
    endfunction

endpackage

// File: rtl/regfile_uart_rsp_parser.sv
// Byte-serial parser for "<AA=DDDD/>" replies. Bytes before the first '<'
// are skipped. done_o/err_o are combinational for the byte being presented,
// so the master can finish in the same cycle the terminating byte arrives.
module regfile_uart_rsp_parser
    import regfile_uart_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        restart_i,
    input  logic        strb_i,
    input  logic [7:0]  byte_i,
    output logic        done_o,
    output rsp_err_t    err_o,
    output logic [7:0]  addr_o,
    output logic [15:0] data_o
);

    // pos 0 hunts for '<'; 1-2 addr digits; 3 '='; 4-7 data digits; 8 '/'; 9 '>'
    logic [3:0]  pos_q, pos_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [4:0]  hx;
    logic        bad;

    // Next field position and digit accumulation for the presented byte
    always_comb begin
        pos_d  = pos_q;
        addr_d = addr_q;
        data_d = data_q;
        done_o = 1'b0;
        err_o  = ERR_OK;
        bad    = 1'b0;
        hx     = ascii2hex(byte_i);
        if (restart_i) begin
            pos_d = 4'd0;
        end else if (strb_i) begin
            case (pos_q)
                4'd0: if (byte_i == SOP) pos_d = 4'd1;
                4'd1, 4'd2: begin
                    if (hx[4]) addr_d = {addr_q[3:0], hx[3:0]};
                    else       bad = 1'b1;
                end
                4'd3: bad = (byte_i != EQ);
                4'd4, 4'd5, 4'd6, 4'd7: begin
                    if (hx[4]) data_d = {data_q[11:0], hx[3:0]};
                    else       bad = 1'b1;
                end
                4'd8: bad = (byte_i != EOP1);
                4'd9: bad = (byte_i != EOP2);
                default: bad = 1'b1;
            endcase
            if (pos_q != 4'd0)
                pos_d = pos_q + 4'd1;
            if (bad || pos_q == 4'd9) begin
                done_o = 1'b1;
                err_o  = bad ? ERR_MALFORMED : ERR_OK;
                pos_d  = 4'd0;
            end
        end
    end

    // Parser state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pos_q  <= 4'd0;
            addr_q <= 8'h00;
            data_q <= 16'h0000;
        end else begin
            pos_q  <= pos_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/regfile_uart_master.sv
// Host-side register-file initiator: serialises one read/write command into
// an ASCII frame for the UART TX FIFO and parses the reply from the RX FIFO.
// Build option REGFILE_MASTER_WR_ACK_EN: writes also wait for the slave echo
// and check it against the written data.
//
// state     | meaning
// IDLE      | ready for a command when RX FIFO empty; drains stray RX bytes
// TX_SEND   | push frame byte (holds while TX FIFO full)
// TX_GAP    | idle cycle between TX bytes; decides next phase after last byte
// RX_WAIT   | wait for RX data, timeout counter running
// RX_RD     | RX FIFO read strobe
// RX_CHK    | RX head byte valid, fed to the parser
// DONE      | one-cycle response strobe
module regfile_uart_master
    import regfile_uart_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1152000
)
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WRITE,
    input  logic [4:0]  CMD_ADDR,
    input  logic [15:0] CMD_WDATA,
    output logic        RSP_VALID,
    output logic [4:0]  RSP_ADDR,
    output logic [15:0] RSP_DATA,
    output logic [1:0]  RSP_ERR,
    input  logic        TX_FIFO_FULL,
    output logic [7:0]  TX_BYTE,
    output logic        TX_FIFO_WR_REQ,
    input  logic [3:0]  RX_FIFO_LEVEL,
    input  logic [7:0]  RX_FIFO_Q,
    output logic        RX_FIFO_RD_REQ
);

`ifdef REGFILE_MASTER_WR_ACK_EN
    localparam bit WR_ACK = 1'b1;
`else
    localparam bit WR_ACK = 1'b0;
`endif

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    // The transition into DONE uses up one cycle, so loading one less puts
    // RSP_VALID exactly TIMEOUT_CYC cycles after the last TX byte.
    localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TX_SEND, S_TX_GAP, S_RX_WAIT, S_RX_RD, S_RX_CHK, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic        drain_q, drain_d;
    logic [4:0]  rsp_addr_q, rsp_addr_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    rsp_err_t    rsp_err_q, rsp_err_d;

    logic [7:0]  frame_byte;
    logic [3:0]  last_idx;
    logic        expire;
    logic        can_accept;
    logic        prs_strb, prs_restart, prs_done;
    rsp_err_t    prs_err;
    logic [7:0]  prs_addr;
    logic [15:0] prs_data;

    regfile_uart_rsp_parser u_parser (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .restart_i (prs_restart),
        .strb_i    (prs_strb),
        .byte_i    (RX_FIFO_Q),
        .done_o    (prs_done),
        .err_o     (prs_err),
        .addr_o    (prs_addr),
        .data_o    (prs_data)
    );

    assign last_idx = write_q ? 4'd9 : 4'd6;
    assign expire   = (cnt_q <= CW'(1));

    // Frame byte selected by the TX index
    always_comb begin
        frame_byte = SOP;
        case (idx_q)
            4'd1: frame_byte = hex2ascii({3'b000, addr_q[4]});
            4'd2: frame_byte = hex2ascii(addr_q[3:0]);
            4'd3: frame_byte = EQ;
            4'd4: frame_byte = write_q ? hex2ascii(wdata_q[15:12]) : REQ;
            4'd5: frame_byte = write_q ? hex2ascii(wdata_q[11:8])  : EOP1;
            4'd6: frame_byte = write_q ? hex2ascii(wdata_q[7:4])   : EOP2;
            4'd7: frame_byte = hex2ascii(wdata_q[3:0]);
            4'd8: frame_byte = EOP1;
            4'd9: frame_byte = EOP2;
            default: frame_byte = SOP;
        endcase
    end

    // Next-state, FIFO handshakes and response capture
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        write_d        = write_q;
        drain_d        = 1'b0;
        rsp_addr_d     = rsp_addr_q;
        rsp_data_d     = rsp_data_q;
        rsp_err_d      = rsp_err_q;
        can_accept     = 1'b0;
        CMD_READY      = 1'b0;
        RSP_VALID      = 1'b0;
        TX_BYTE        = 8'h00;
        TX_FIFO_WR_REQ = 1'b0;
        RX_FIFO_RD_REQ = 1'b0;
        prs_strb       = 1'b0;
        prs_restart    = 1'b0;
        case (state_q)
            S_IDLE: begin
                can_accept = (RX_FIFO_LEVEL == 4'd0);
                CMD_READY  = can_accept;
                // Reads are spaced so the FIFO level is current before the next one
                if (RX_FIFO_LEVEL != 4'd0 && !drain_q) begin
                    RX_FIFO_RD_REQ = 1'b1;
                    drain_d        = 1'b1;
                end
                if (CMD_VALID && can_accept) begin
                    addr_d      = CMD_ADDR;
                    wdata_d     = CMD_WDATA;
                    write_d     = CMD_WRITE;
                    idx_d       = 4'd0;
                    prs_restart = 1'b1;
                    state_d     = S_TX_SEND;
                end
            end
            S_TX_SEND: begin
                if (!TX_FIFO_FULL) begin
                    TX_FIFO_WR_REQ = 1'b1;
                    TX_BYTE        = frame_byte;
                    if (idx_q == last_idx)
                        cnt_d = CNT_LOAD;
                    state_d = S_TX_GAP;
                end
            end
            S_TX_GAP: begin
                if (idx_q == last_idx) begin
                    cnt_d = cnt_q - CW'(1);
                    if (write_q && !WR_ACK) begin
                        rsp_data_d = 16'h0000;
                        rsp_err_d  = ERR_OK;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_RX_WAIT;
                    end
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_TX_SEND;
                end
            end
            S_RX_WAIT, S_RX_RD, S_RX_CHK: begin
                cnt_d = cnt_q - CW'(1);
                if (expire) begin
                    rsp_data_d = 16'h0000;
                    rsp_err_d  = ERR_TIMEOUT;
                    state_d    = S_DONE;
                end else if (state_q == S_RX_WAIT) begin
                    if (RX_FIFO_LEVEL != 4'd0)
                        state_d = S_RX_RD;
                end else if (state_q == S_RX_RD) begin
                    RX_FIFO_RD_REQ = 1'b1;
                    state_d        = S_RX_CHK;
                end else begin
                    prs_strb = 1'b1;
                    state_d  = S_RX_WAIT;
                    if (prs_done) begin
                        state_d    = S_DONE;
                        rsp_data_d = 16'h0000;
                        if (prs_err != ERR_OK)
                            rsp_err_d = ERR_MALFORMED;
                        else if (prs_addr != {3'b000, addr_q})
                            rsp_err_d = ERR_ADDR;
                        else if (WR_ACK && write_q && prs_data != wdata_q)
                            rsp_err_d = ERR_MALFORMED;
                        else begin
                            rsp_err_d  = ERR_OK;
                            rsp_data_d = prs_data;
                        end
                    end
                end
            end
            S_DONE: begin
                RSP_VALID = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_DONE && state_q != S_DONE)
            rsp_addr_d = addr_q;
    end

    // State and datapath registers; drain_q resets high so no read fires in the first cycle out of reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            idx_q      <= 4'd0;
            cnt_q      <= '0;
            addr_q     <= 5'd0;
            wdata_q    <= 16'h0000;
            write_q    <= 1'b0;
            drain_q    <= 1'b1;
            rsp_addr_q <= 5'd0;
            rsp_data_q <= 16'h0000;
            rsp_err_q  <= ERR_OK;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            drain_q    <= drain_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign RSP_ADDR = rsp_addr_q;
    assign RSP_DATA = rsp_data_q;
    assign RSP_ERR  = rsp_err_q;

endmodule

// File: tb/tb_regfile_uart_master.sv
// Directed bench for regfile_uart_master with TX/RX FIFO models.
module tb_regfile_uart_master;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic        CMD_WRITE;
    logic [4:0]  CMD_ADDR;
    logic [15:0] CMD_WDATA;
    logic        RSP_VALID;
    logic [4:0]  RSP_ADDR;
    logic [15:0] RSP_DATA;
    logic [1:0]  RSP_ERR;
    logic        TX_FIFO_FULL;
    logic [7:0]  TX_BYTE;
    logic        TX_FIFO_WR_REQ;
    logic [3:0]  RX_FIFO_LEVEL = 4'd0;
    logic [7:0]  RX_FIFO_Q = 8'h00;
    logic        RX_FIFO_RD_REQ;

    regfile_uart_master #(.TIMEOUT_CYC(100)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .CMD_VALID      (CMD_VALID),
        .CMD_READY      (CMD_READY),
        .CMD_WRITE      (CMD_WRITE),
        .CMD_ADDR       (CMD_ADDR),
        .CMD_WDATA      (CMD_WDATA),
        .RSP_VALID      (RSP_VALID),
        .RSP_ADDR       (RSP_ADDR),
        .RSP_DATA       (RSP_DATA),
        .RSP_ERR        (RSP_ERR),
        .TX_FIFO_FULL   (TX_FIFO_FULL),
        .TX_BYTE        (TX_BYTE),
        .TX_FIFO_WR_REQ (TX_FIFO_WR_REQ),
        .RX_FIFO_LEVEL  (RX_FIFO_LEVEL),
        .RX_FIFO_Q      (RX_FIFO_Q),
        .RX_FIFO_RD_REQ (RX_FIFO_RD_REQ)
    );

    always #5 CLK = ~CLK;

    logic [7:0] tx_mem [0:255];
    logic [7:0] rx_mem [0:255];
    int tx_wp = 0;
    int rx_wp = 0;
    int rx_rp = 0;
    int cyc = 0;
    int last_tx_cyc = 0;
    int acc_cyc = 0;
    int rsp_cyc = 0;
    int rsp_cnt = 0;
    int wr_full_viol = 0;
    int rd_underflow = 0;
    logic [4:0]  cap_addr = 5'd0;
    logic [15:0] cap_data = 16'h0;
    logic [1:0]  cap_err = 2'd0;

    int total = 0;
    int bad = 0;

    // FIFO models and response monitor, evaluated away from the active edge
    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (TX_FIFO_WR_REQ) begin
            tx_mem[8'(tx_wp)] = TX_BYTE;
            tx_wp = tx_wp + 1;
            last_tx_cyc = cyc;
            if (TX_FIFO_FULL) wr_full_viol = wr_full_viol + 1;
        end
        if (RX_FIFO_RD_REQ) begin
            if (rx_rp < rx_wp) begin
                RX_FIFO_Q = rx_mem[8'(rx_rp)];
                rx_rp = rx_rp + 1;
            end else begin
                rd_underflow = rd_underflow + 1;
            end
        end
        RX_FIFO_LEVEL = (rx_wp - rx_rp > 15) ? 4'd15 : 4'(rx_wp - rx_rp);
        if (CMD_VALID && CMD_READY) acc_cyc = cyc;
        if (RSP_VALID) begin
            rsp_cnt  = rsp_cnt + 1;
            rsp_cyc  = cyc;
            cap_addr = RSP_ADDR;
            cap_data = RSP_DATA;
            cap_err  = RSP_ERR;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic w, input logic [4:0] a, input logic [15:0] d);
        int n;
        n = 0;
        while (!CMD_READY && n < 200) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", 32'(CMD_READY), 32'd1);
        CMD_WRITE = w;
        CMD_ADDR  = a;
        CMD_WDATA = d;
        CMD_VALID = 1'b1;
        tick();
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_tx(input int target, input string tag);
        int n;
        n = 0;
        while (tx_wp < target && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(tx_wp), 32'(target));
    endtask

    task automatic wait_rsp(input int prev, input int max, input string tag);
        int n;
        n = 0;
        while (rsp_cnt == prev && n < max) begin
            tick();
            n++;
        end
        chk(tag, 32'(rsp_cnt), 32'(prev + 1));
    endtask

    task automatic chk_frame(input int base, input string exp, input string tag);
        chk({tag, "_len"}, 32'(tx_wp - base), 32'(exp.len()));
        for (int i = 0; i < exp.len(); i++)
            chk(tag, 32'(tx_mem[8'(base + i)]), 32'(exp[i]));
    endtask

    task automatic push_rx(input string s);
        for (int i = 0; i < s.len(); i++) begin
            rx_mem[8'(rx_wp)] = s[i];
            rx_wp = rx_wp + 1;
        end
    endtask

    initial begin
        int base;
        int r0;
        int rp0;
        int n0;
        int n;
        RESET = 1'b1;
        CMD_VALID = 1'b0;
        CMD_WRITE = 1'b0;
        CMD_ADDR = 5'd0;
        CMD_WDATA = 16'h0;
        TX_FIFO_FULL = 1'b0;
        repeat (3) tick();
        RESET = 1'b0;

        // reset state
        chk("rst_cmd_ready", 32'(CMD_READY), 32'd1);
        chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("rst_tx_wr", 32'(TX_FIFO_WR_REQ), 32'd0);
        chk("rst_rx_rd", 32'(RX_FIFO_RD_REQ), 32'd0);
        chk("rst_tx_byte", 32'(TX_BYTE), 32'd0);
        chk("rst_rsp_err", 32'(RSP_ERR), 32'd0);

        // 1: write 0x12 <= 0xABCD
        base = tx_wp; r0 = rsp_cnt;
        send_cmd(1'b1, 5'h12, 16'hABCD);
        wait_rsp(r0, 100, "wr_rsp_seen");
        chk_frame(base, "<12=ABCD/>", "wr_frame");
        chk("wr_latency", 32'(rsp_cyc - acc_cyc), 32'd21);
        chk("wr_err", 32'(cap_err), 32'd0);
        chk("wr_addr", 32'(cap_addr), 32'h12);
        chk("wr_data", 32'(cap_data), 32'h0);

        // 2: read 0x05 with a good reply
        base = tx_wp; r0 = rsp_cnt;
        send_cmd(1'b0, 5'h05, 16'h0);
        wait_tx(base + 7, "rd_tx_wait");
        chk_frame(base, "<05=?/>", "rd_frame");
        push_rx("<05=01F0/>");
        wait_rsp(r0, 200, "rd_rsp_seen");
        chk("rd_data", 32'(cap_data), 32'h01F0);
        chk("rd_addr", 32'(cap_addr), 32'h05);
        chk("rd_err", 32'(cap_err), 32'd0);

        // 3: read with no reply -> timeout
        base = tx_wp; r0 = rsp_cnt;
        send_cmd(1'b0, 5'h07, 16'h0);
        wait_tx(base + 7, "to_tx_wait");
        wait_rsp(r0, 300, "to_rsp_seen");
        chk("to_err", 32'(cap_err), 32'd1);
        chk("to_latency", 32'(rsp_cyc - last_tx_cyc), 32'd100);
        chk("to_data", 32'(cap_data), 32'h0);
        chk("to_addr", 32'(cap_addr), 32'h07);

        // 4a: address mismatch
        base = tx_wp; r0 = rsp_cnt;
        send_cmd(1'b0, 5'h05, 16'h0);
        wait_tx(base + 7, "am_tx_wait");
        push_rx("<06=1234/>");
        wait_rsp(r0, 200, "am_rsp_seen");
        chk("am_err", 32'(cap_err), 32'd3);
        chk("am_data", 32'(cap_data), 32'h0);

        // 4b: malformed reply, leftovers drained before ready
        base = tx_wp; r0 = rsp_cnt;
        send_cmd(1'b0, 5'h05, 16'h0);
        wait_tx(base + 7, "mf_tx_wait");
        rp0 = rx_rp;
        push_rx("<05=12x4/>");
        wait_rsp(r0, 200, "mf_rsp_seen");
        chk("mf_err", 32'(cap_err), 32'd2);
        chk("mf_bytes_at_x", 32'(rx_rp - rp0), 32'd7);
        chk("mf_not_ready", 32'(CMD_READY), 32'd0);
        n = 0;
        while (!CMD_READY && n < 100) begin
            tick();
            n++;
        end
        chk("mf_ready_after_drain", 32'(CMD_READY), 32'd1);
        chk("mf_drained", 32'(rx_wp - rx_rp), 32'd0);

        // 5: TX FIFO full mid-frame
        base = tx_wp; r0 = rsp_cnt;
        send_cmd(1'b1, 5'h03, 16'h5A0F);
        wait_tx(base + 3, "full_tx_wait");
        TX_FIFO_FULL = 1'b1;
        n0 = tx_wp;
        repeat (50) tick();
        chk("full_no_push", 32'(tx_wp), 32'(n0));
        TX_FIFO_FULL = 1'b0;
        wait_rsp(r0, 100, "full_rsp_seen");
        chk_frame(base, "<03=5A0F/>", "full_frame");
        chk("full_err", 32'(cap_err), 32'd0);

        // 6: reset mid-reply, then garbage before a valid reply
        base = tx_wp;
        send_cmd(1'b0, 5'h05, 16'h0);
        wait_tx(base + 7, "mr_tx_wait");
        push_rx("<05=77");
        repeat (6) tick();
        r0 = rsp_cnt;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("mr_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("mr_tx_wr", 32'(TX_FIFO_WR_REQ), 32'd0);
        chk("mr_rx_rd", 32'(RX_FIFO_RD_REQ), 32'd0);
        chk("mr_tx_byte", 32'(TX_BYTE), 32'd0);
        chk("mr_rsp_addr", 32'(RSP_ADDR), 32'd0);
        chk("mr_rsp_data", 32'(RSP_DATA), 32'd0);
        chk("mr_rsp_err", 32'(RSP_ERR), 32'd0);
        repeat (20) tick();
        chk("mr_no_rsp", 32'(rsp_cnt), 32'(r0));
        base = tx_wp; r0 = rsp_cnt;
        send_cmd(1'b0, 5'h0A, 16'h0);
        wait_tx(base + 7, "gb_tx_wait");
        chk_frame(base, "<0A=?/>", "gb_frame");
        push_rx("zz<0A=BEEF/>");
        wait_rsp(r0, 200, "gb_rsp_seen");
        chk("gb_data", 32'(cap_data), 32'hBEEF);
        chk("gb_addr", 32'(cap_addr), 32'h0A);
        chk("gb_err", 32'(cap_err), 32'd0);
        repeat (3) tick();
        chk("gb_hold", 32'(RSP_DATA), 32'hBEEF);

        chk("wr_while_full", 32'(wr_full_viol), 32'd0);
        chk("rx_underflow", 32'(rd_underflow), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
